// File: rtl/dma_channel_arbiter_if.sv
// Bundle between DMA clients, the channel arbiter and the DMA engine.
// slave: arbiter side; master: clients + engine side.
interface dma_channel_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
);
  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ready;
  logic [N_CH*ADDR_W-1:0] ch_src;
  logic [N_CH*ADDR_W-1:0] ch_dst;
  logic [N_CH*LEN_W-1:0]  ch_len;
  logic [N_CH-1:0]        ch_done;
  logic [N_CH-1:0]        ch_busy;
  logic                   eng_start;
  logic [ADDR_W-1:0]      eng_src;
  logic [ADDR_W-1:0]      eng_dst;
  logic [31:0]            eng_len;
  logic                   eng_done;
  logic                   active;
  logic [IW-1:0]          grant_id;

  modport slave (
    input  ch_valid, ch_src, ch_dst, ch_len,
    input  eng_done,
    output ch_ready, ch_done, ch_busy,
    output eng_start, eng_src, eng_dst, eng_len,
    output active, grant_id
  );

  modport master (
    output ch_valid, ch_src, ch_dst, ch_len,
    output eng_done,
    input  ch_ready, ch_done, ch_busy,
    input  eng_start, eng_src, eng_dst, eng_len,
    input  active, grant_id
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Round-robin share of one DMA engine among N_CH descriptor channels.
// Ports: clk, rst_n (async low), bus (slave modport). Option: DMA_ARB_PRIO_EN.
module dma_channel_arbiter #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dma_channel_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N_CH);

`ifdef DMA_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CMPL} state_e;

  state_e              state_q, state_d;
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [ADDR_W-1:0]   esrc_q, esrc_d;
  logic [ADDR_W-1:0]   edst_q, edst_d;
  logic [LEN_W-1:0]    elen_q, elen_d;
  logic [ADDR_W-1:0]   src_q [N_CH];
  logic [ADDR_W-1:0]   dst_q [N_CH];
  logic [LEN_W-1:0]    len_q [N_CH];

  logic [N_CH-1:0]     acc;
  logic [N_CH-1:0]     clr;
  logic [N_CH-1:0]     done;
  logic                start;
  logic [IW-1:0]       win;

  assign acc = bus.ch_valid & ~pending_q;

  // First pending channel at or after rr_q, wrapping.
  // With priority, channel 0 preempts and is skipped by the rotation.
  always_comb begin : sel
    logic          found;
    int            j;
    logic [IW-1:0] jj;
    found = 1'b0;
    win   = '0;
    j     = 0;
    jj    = '0;
    if (PRIO_EN && pending_q[0]) begin
      found = 1'b1;
    end
    for (int k = 0; k < N_CH; k++) begin
      j  = (int'(rr_q) + k) % N_CH;
      jj = IW'(j);
      if (!found && pending_q[jj] &&
          !(PRIO_EN && jj == '0)) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    esrc_d  = esrc_q;
    edst_d  = edst_q;
    elen_d  = elen_q;
    clr     = '0;
    done    = '0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = ISSUE;
          gnt_d   = win;
          esrc_d  = src_q[win];
          edst_d  = dst_q[win];
          elen_d  = len_q[win];
        end
      end
      ISSUE: begin
        // A zero-length job would still move one word.
        if (elen_q != '0) begin
          start   = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = CMPL;
        end
      end
      WAIT: begin
        if (bus.eng_done) state_d = CMPL;
      end
      CMPL: begin
        done[gnt_q] = 1'b1;
        clr[gnt_q]  = 1'b1;
        if (!(PRIO_EN && gnt_q == '0)) begin
          rr_d = (gnt_q == IW'(N_CH - 1)) ? '0 : gnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_d = (pending_q | acc) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      esrc_q    <= '0;
      edst_q    <= '0;
      elen_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      esrc_q    <= esrc_d;
      edst_q    <= edst_d;
      elen_q    <= elen_d;
      for (int i = 0; i < N_CH; i++) begin
        if (acc[i]) begin
          src_q[i] <= bus.ch_src[i*ADDR_W +: ADDR_W];
          dst_q[i] <= bus.ch_dst[i*ADDR_W +: ADDR_W];
          len_q[i] <= bus.ch_len[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  // Ready is forced low while reset is asserted.
  assign bus.ch_ready  = ~pending_q & {N_CH{rst_n}};
  assign bus.ch_busy   = pending_q;
  assign bus.ch_done   = done;
  assign bus.eng_start = start;
  assign bus.eng_src   = esrc_q;
  assign bus.eng_dst   = edst_q;
  assign bus.eng_len   = 32'(elen_q);
  assign bus.active    = (state_q != IDLE);
  assign bus.grant_id  = gnt_q;
endmodule
